// File: rtl/sbox_share_sched.sv
// Shares NUM_SBOX byte S-boxes between SubBytes (16 bytes) and SubWord (4 bytes); response one cycle after the last beat.
// Round-robin grant on contention; no response backpressure, requests wait in IDLE via ready.
module sbox_share_sched #(
  parameter int NUM_SBOX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sb_req_valid,
  output logic                  sb_req_ready,
  input  logic [127:0]          sb_req_state,
  output logic                  sb_rsp_valid,
  output logic [127:0]          sb_rsp_state,
  input  logic                  kw_req_valid,
  output logic                  kw_req_ready,
  input  logic [31:0]           kw_req_word,
  output logic                  kw_rsp_valid,
  output logic [31:0]           kw_rsp_word,
  output logic [8*NUM_SBOX-1:0] sbox_in,
  input  logic [8*NUM_SBOX-1:0] sbox_out,
  output logic                  busy
);

  localparam int LW   = 8 * NUM_SBOX;
  localparam int B_SB = 16 / NUM_SBOX;
  localparam int B_KW = 4 / NUM_SBOX;

  generate
    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
      $error("sbox_share_sched: NUM_SBOX must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SB_RUN, KW_RUN, RESP} state_t;

  state_t         state_q, state_d;
  logic [3:0]     beat_q, beat_d;
  logic [127:0]   op_q;
  logic [127:0]   sb_res_q;
  logic [31:0]    kw_res_q;
  // Last granted requester; also identifies the owner of the operation in flight.
  logic           last_kw_q;
  logic           grant_sb, grant_kw;
  logic           both_vld;
  logic [6:0]     lane_base;
  logic [4:0]     kw_base;

  assign both_vld  = sb_req_valid && kw_req_valid;
  assign lane_base = 7'(beat_q * LW);
  assign kw_base   = 5'(beat_q * LW);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    sb_req_ready = 1'b0;
    kw_req_ready = 1'b0;
    grant_sb     = 1'b0;
    grant_kw     = 1'b0;
    case (state_q)
      IDLE: begin
        // Under contention only the requester that did not win last time sees ready.
        sb_req_ready = !(both_vld && !last_kw_q);
        kw_req_ready = !(both_vld && last_kw_q);
        grant_sb     = sb_req_valid && sb_req_ready;
        grant_kw     = kw_req_valid && kw_req_ready;
        beat_d       = '0;
        if (grant_sb) begin
          state_d = SB_RUN;
        end else if (grant_kw) begin
          state_d = KW_RUN;
        end
      end
      SB_RUN: begin
        if (beat_q == 4'(B_SB - 1)) begin
          state_d = RESP;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      KW_RUN: begin
        if (beat_q == 4'(B_KW - 1)) begin
          state_d = RESP;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        beat_d  = '0;
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    sbox_in = '0;
    if (state_q == SB_RUN || state_q == KW_RUN) begin
      sbox_in = op_q[lane_base +: LW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      op_q      <= '0;
      sb_res_q  <= '0;
      kw_res_q  <= '0;
      last_kw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (grant_sb) begin
        op_q      <= sb_req_state;
        last_kw_q <= 1'b0;
      end else if (grant_kw) begin
        op_q      <= {96'b0, kw_req_word};
        last_kw_q <= 1'b1;
      end
      if (state_q == SB_RUN) begin
        sb_res_q[lane_base +: LW] <= sbox_out;
      end
      if (state_q == KW_RUN) begin
        kw_res_q[kw_base +: LW] <= sbox_out;
      end
    end
  end

  assign sb_rsp_valid = (state_q == RESP) && !last_kw_q;
  assign kw_rsp_valid = (state_q == RESP) && last_kw_q;
  assign sb_rsp_state = sb_res_q;
  assign kw_rsp_word  = kw_res_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_share_sched.sv
// Randomized and directed bench for sbox_share_sched against a transaction-level model.
module tb_sbox_share_sched;

  localparam int N = 4;
  localparam logic [2047:0] SBOX_TBL = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
    return r;
  endfunction

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sb_req_valid = 1'b0, kw_req_valid = 1'b0;
  logic           sb_req_ready, kw_req_ready, sb_rsp_valid, kw_rsp_valid, busy;
  logic [127:0]   sb_req_state = '0;
  logic [127:0]   sb_rsp_state;
  logic [31:0]    kw_req_word = '0;
  logic [31:0]    kw_rsp_word;
  logic [8*N-1:0] sbox_in, sbox_out;

  // Second build with a single S-box lane.
  logic           d1_sb_valid = 1'b0, d1_kw_valid = 1'b0;
  logic           d1_sb_ready, d1_kw_ready, d1_sb_rsp_valid, d1_kw_rsp_valid, d1_busy;
  logic [127:0]   d1_sb_state = '0;
  logic [127:0]   d1_sb_rsp_state;
  logic [31:0]    d1_kw_word = '0;
  logic [31:0]    d1_kw_rsp_word;
  logic [7:0]     d1_sbox_in, d1_sbox_out;

  always #5 clk = ~clk;

  sbox_share_sched #(.NUM_SBOX(N)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .sb_req_valid(sb_req_valid), .sb_req_ready(sb_req_ready), .sb_req_state(sb_req_state),
    .sb_rsp_valid(sb_rsp_valid), .sb_rsp_state(sb_rsp_state),
    .kw_req_valid(kw_req_valid), .kw_req_ready(kw_req_ready), .kw_req_word(kw_req_word),
    .kw_rsp_valid(kw_rsp_valid), .kw_rsp_word(kw_rsp_word),
    .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy)
  );

  sbox_share_sched #(.NUM_SBOX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .sb_req_valid(d1_sb_valid), .sb_req_ready(d1_sb_ready), .sb_req_state(d1_sb_state),
    .sb_rsp_valid(d1_sb_rsp_valid), .sb_rsp_state(d1_sb_rsp_state),
    .kw_req_valid(d1_kw_valid), .kw_req_ready(d1_kw_ready), .kw_req_word(d1_kw_word),
    .kw_rsp_valid(d1_kw_rsp_valid), .kw_rsp_word(d1_kw_rsp_word),
    .sbox_in(d1_sbox_in), .sbox_out(d1_sbox_out), .busy(d1_busy)
  );

  for (genvar j = 0; j < N; j++) begin : g_sbox
    assign sbox_out[8*j +: 8] = sbox(sbox_in[8*j +: 8]);
  end
  assign d1_sbox_out = sbox(d1_sbox_in);

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: m_t = cycles since acceptance (0 = idle), beats are 1..B, response at B+1.
  int           m_t;
  bit           m_kw;
  bit           m_last_kw;
  logic [127:0] m_op;
  logic [127:0] m_sb_res;
  logic [31:0]  m_kw_res;

  // Values sampled during the most recent step.
  logic         g_sbv, g_kwv, g_sr, g_kr;
  logic [127:0] g_sbr;
  logic [31:0]  g_kwr;
  logic [8*N-1:0] g_in;

  task automatic model_reset();
    m_t = 0; m_kw = 0; m_last_kw = 0; m_op = '0; m_sb_res = '0; m_kw_res = '0;
  endtask

  // Called at a falling edge; drives inputs, checks the current cycle, advances the model.
  task automatic step(input logic sv, input logic [127:0] sd, input logic kv, input logic [31:0] kd);
    int b;
    bit win_kw, exp_sr, exp_kr, exp_sv, exp_kv, run_sb, run_kw;
    logic [8*N-1:0] exp_in;
    sb_req_valid = sv; sb_req_state = sd; kw_req_valid = kv; kw_req_word = kd;
    #1;
    b = m_kw ? 4 / N : 16 / N;
    exp_sr = 0; exp_kr = 0;
    if (m_t == 0) begin
      win_kw = (sv && kv) ? !m_last_kw : kv;
      exp_sr = !(sv && kv) || !win_kw;
      exp_kr = !(sv && kv) || win_kw;
    end
    exp_in = (m_t >= 1 && m_t <= b) ? m_op[(m_t - 1) * 8 * N +: 8 * N] : '0;
    exp_sv = (m_t == b + 1) && !m_kw;
    exp_kv = (m_t == b + 1) && m_kw;
    run_sb = (m_t >= 1 && m_t <= b) && !m_kw;
    run_kw = (m_t >= 1 && m_t <= b) && m_kw;
    if (exp_sv) m_sb_res = sub_state(m_op);
    if (exp_kv) m_kw_res = sub_word(m_op[31:0]);
    chk("sb_ready", sb_req_ready, exp_sr);
    chk("kw_ready", kw_req_ready, exp_kr);
    chk("busy", busy, m_t != 0);
    chk("sbox_in", sbox_in, exp_in);
    chk("sb_rsp_valid", sb_rsp_valid, exp_sv);
    chk("kw_rsp_valid", kw_rsp_valid, exp_kv);
    if (!run_sb) chk("sb_rsp_state", sb_rsp_state, m_sb_res);
    if (!run_kw) chk("kw_rsp_word", kw_rsp_word, m_kw_res);
    g_sbv = sb_rsp_valid; g_kwv = kw_rsp_valid; g_sr = sb_req_ready; g_kr = kw_req_ready;
    g_sbr = sb_rsp_state; g_kwr = kw_rsp_word; g_in = sbox_in;
    if (m_t == 0) begin
      if (sv && exp_sr) begin
        m_t = 1; m_kw = 0; m_last_kw = 0; m_op = sd;
      end else if (kv && exp_kr) begin
        m_t = 1; m_kw = 1; m_last_kw = 1; m_op = {96'b0, kd};
      end
    end else if (m_t == b + 1) begin
      m_t = 0;
    end else begin
      m_t++;
    end
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, $urandom);
  endtask

  task automatic do_reset();
    sb_req_valid = 0; kw_req_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_sbox_in", sbox_in, '0);
    chk("rst_sb_rsp_valid", sb_rsp_valid, 1'b0);
    chk("rst_kw_rsp_valid", kw_rsp_valid, 1'b0);
    chk("rst_sb_rsp_state", sb_rsp_state, '0);
    chk("rst_kw_rsp_word", kw_rsp_word, '0);
    chk("rst_readies", {sb_req_ready, kw_req_ready}, 2'b11);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int lat, kw_seen, grants_kw[$];
    logic [127:0] res;
    logic [31:0] exp_in2 [4];
    logic [31:0] got_in2 [4];
    exp_in2 = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c};
    model_reset();
    @(negedge clk);
    do_reset();

    // SubBytes of all-zero state.
    step(1'b1, 128'h0, 1'b0, 32'h0);
    lat = 0; kw_seen = 0; res = '0;
    for (int i = 1; i <= 8; i++) begin
      idle_step();
      if (g_sbv && lat == 0) begin lat = i; res = g_sbr; end
      if (g_kwv) kw_seen = 1;
    end
    chk("t1_latency", lat, 5);
    chk("t1_data", res, {16{8'h63}});
    chk("t1_kw_quiet", kw_seen, 0);

    // Beat ordering on the S-box lanes.
    step(1'b1, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 32'h0);
    res = '0;
    for (int i = 1; i <= 6; i++) begin
      idle_step();
      if (i <= 4) got_in2[i-1] = g_in;
      if (g_sbv) res = g_sbr;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t2_sbox_in_%0d", i), got_in2[i], exp_in2[i]);
    chk("t2_data", res, 128'h76abd7fe2b670130c56f6bf27b777c63);

    // SubWord latency and ready return.
    step(1'b0, 128'h0, 1'b1, 32'h01020304);
    lat = 0; res = '0;
    for (int i = 1; i <= 5; i++) begin
      idle_step();
      if (g_kwv && lat == 0) begin lat = i; res = {96'b0, g_kwr}; end
      if (i == 2) chk("t3_ready_low", g_kr, 1'b0);
      if (i == 3) chk("t3_ready_back", g_kr, 1'b1);
    end
    chk("t3_latency", lat, 2);
    chk("t3_data", res, {96'b0, 32'h7c777bf2});

    // Contention right after reset: KW first, then alternation.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, $urandom);
      if (g_kr) grants_kw.push_back(1);
      else if (g_sr) grants_kw.push_back(0);
    end
    chk("t4_grant_count_ge4", grants_kw.size() >= 4, 1'b1);
    if (grants_kw.size() >= 4) begin
      chk("t4_grant0_kw", grants_kw[0], 1);
      chk("t4_grant1_sb", grants_kw[1], 0);
      chk("t4_grant2_kw", grants_kw[2], 1);
      chk("t4_grant3_sb", grants_kw[3], 0);
    end

    // Reset asserted mid-way through a SubBytes operation.
    do_reset();
    step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 32'h0);
    idle_step();
    rst_n = 0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_sbox_in", sbox_in, '0);
    chk("t5_sb_rsp_valid", sb_rsp_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      idle_step();
      if (i == 0) chk("t5_readies", {g_sr, g_kr}, 2'b11);
      if (g_sbv) lat = 1;
    end
    chk("t5_no_rsp", lat, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) != 0, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom);
    end
    for (int i = 0; i < 20; i++) idle_step();

    // Single-lane build latencies.
    d1_kw_valid = 1; d1_kw_word = 32'h01020304;
    @(negedge clk);
    d1_kw_valid = 0;
    lat = 0; res = '0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      if (d1_kw_rsp_valid && lat == 0) begin lat = i; res = {96'b0, d1_kw_rsp_word}; end
      @(negedge clk);
    end
    chk("t6_kw_latency", lat, 5);
    chk("t6_kw_data", res, {96'b0, 32'h7c777bf2});
    d1_sb_valid = 1; d1_sb_state = 128'h0;
    @(negedge clk);
    d1_sb_valid = 0;
    lat = 0; res = '0;
    for (int i = 1; i <= 25; i++) begin
      #1;
      if (d1_sb_rsp_valid && lat == 0) begin lat = i; res = d1_sb_rsp_state; end
      @(negedge clk);
    end
    chk("t6_sb_latency", lat, 17);
    chk("t6_sb_data", res, {16{8'h63}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
